// File: rtl/instruction_fetch_stage_if.sv
// Signal bundle between the fetch stage and the rest of the pipeline:
// hazard/redirect controls, instruction-memory port and the IF/ID outputs.
// Optional macro FETCH_PERF_CNT_EN adds the performance counter outputs.
interface instruction_fetch_stage_if;
   logic        Stall;
   logic        Flush;
   logic        PCSrc;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [31:0] JumpTarget;
   logic [31:0] IMemAddr;
   logic [31:0] IMemData;
   logic [31:0] InstructionOut;
   logic [31:0] PCAddResultOut;
   logic [31:0] PCOut;
   logic        ValidOut;
   logic        AlignFault;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] FetchCount;
   logic [31:0] StallCount;
   logic [31:0] RedirectCount;
`endif

   // Pipeline / hazard unit / memory side
   modport master (
      output Stall, Flush, PCSrc, BranchTarget, Jump, JumpTarget, IMemData,
`ifdef FETCH_PERF_CNT_EN
      input  FetchCount, StallCount, RedirectCount,
`endif
      input  IMemAddr, InstructionOut, PCAddResultOut, PCOut, ValidOut, AlignFault
   );

   // Fetch stage side
   modport slave (
      input  Stall, Flush, PCSrc, BranchTarget, Jump, JumpTarget, IMemData,
`ifdef FETCH_PERF_CNT_EN
      output FetchCount, StallCount, RedirectCount,
`endif
      output IMemAddr, InstructionOut, PCAddResultOut, PCOut, ValidOut, AlignFault
   );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Pipeline front end: PC register, PC+4 adder, redirect mux and IF/ID register.
// Edge priority: Reset > PCSrc > Jump > Stall > Flush > normal fetch.
// Optional macro FETCH_PERF_CNT_EN adds fetch/stall/redirect counters.
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input logic                     Clk,
   input logic                     Reset,
   instruction_fetch_stage_if.slave fif
);

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      STALL    = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] pcout_q, pcout_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic        fetch_inc;
   logic        redirect_inc;

   logic [31:0] pc_plus4;
   logic [31:0] target_raw;
   logic        redirect;

   // Branch from EX/MEM is older than the jump in ID, so it wins the mux
   assign pc_plus4   = pc_q + 32'd4;
   assign redirect   = fif.PCSrc | fif.Jump;
   assign target_raw = fif.PCSrc ? fif.BranchTarget : fif.JumpTarget;

   // Next-state and next-IF/ID selection in priority order
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      pc4_d        = pc4_q;
      pcout_d      = pcout_q;
      valid_d      = valid_q;
      fault_d      = fault_q;
      fetch_inc    = 1'b0;
      redirect_inc = 1'b0;

      if (state_q == BOOT) begin
         // First cycle out of reset: keep the bubble, leave PC at RESET_PC
         instr_d = NOP_WORD;
         pc4_d   = 32'd0;
         pcout_d = 32'd0;
         valid_d = 1'b0;
         state_d = RUN;
      end else if (redirect) begin
         // Target low bits are dropped; a misaligned target is remembered
         pc_d         = {target_raw[31:2], 2'b00};
         fault_d      = fault_q | (|target_raw[1:0]);
         instr_d      = NOP_WORD;
         pc4_d        = 32'd0;
         pcout_d      = 32'd0;
         valid_d      = 1'b0;
         redirect_inc = 1'b1;
         state_d      = REDIRECT;
      end else if (fif.Stall) begin
         // Freeze PC and IF/ID; a coincident Flush is ignored
         state_d = STALL;
      end else if (fif.Flush) begin
         pc_d    = pc_plus4;
         instr_d = NOP_WORD;
         pc4_d   = 32'd0;
         pcout_d = 32'd0;
         valid_d = 1'b0;
         state_d = RUN;
      end else begin
         pc_d      = pc_plus4;
         instr_d   = fif.IMemData;
         pc4_d     = pc_plus4;
         pcout_d   = pc_q;
         valid_d   = 1'b1;
         fetch_inc = 1'b1;
         state_d   = RUN;
      end
   end

   // State, PC and IF/ID registers with synchronous active-low reset
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         instr_q <= NOP_WORD;
         pc4_q   <= 32'd0;
         pcout_q <= 32'd0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         pcout_q <= pcout_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   assign fif.IMemAddr       = pc_q;
   assign fif.InstructionOut = instr_q;
   assign fif.PCAddResultOut = pc4_q;
   assign fif.PCOut          = pcout_q;
   assign fif.ValidOut       = valid_q;
   assign fif.AlignFault     = fault_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;
   logic [31:0] redirect_cnt_q;

   // Free-running performance counters, wrapping modulo 2^32
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         fetch_cnt_q    <= 32'd0;
         stall_cnt_q    <= 32'd0;
         redirect_cnt_q <= 32'd0;
      end else begin
         if (fetch_inc)
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (state_q == STALL)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (redirect_inc)
            redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
   end

   assign fif.FetchCount    = fetch_cnt_q;
   assign fif.StallCount    = stall_cnt_q;
   assign fif.RedirectCount = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: the stimulus process runs a
// behavioural model and queues the expected post-edge outputs; the monitor
// pops one record after every rising edge and compares.
module tb_instruction_fetch_stage;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TB_NOP      = 32'hFEED_0000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic [31:0] pcout;
      logic        valid;
      logic        fault;
      logic [31:0] fc;
      logic [31:0] sc;
      logic [31:0] rc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;
   bit   done;
   exp_t exp_q[$];

   // Model state
   logic [31:0] m_pc, m_instr, m_pc4, m_pcout, m_fc, m_sc, m_rc;
   logic        m_valid, m_fault;
   bit          m_boot, m_in_stall;

   instruction_fetch_stage_if fif();

   instruction_fetch_stage #(
      .RESET_PC(TB_RESET_PC),
      .NOP_WORD(TB_NOP)
   ) dut (
      .Clk  (clk),
      .Reset(rst_n),
      .fif  (fif)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign fif.IMemData = mem_word(fif.IMemAddr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic make_bubble();
      m_instr = TB_NOP;
      m_pc4   = 32'd0;
      m_pcout = 32'd0;
      m_valid = 1'b0;
   endtask

   // Apply one cycle of inputs, advance the model by one edge, queue result
   task automatic drive(input logic r, input logic s, input logic f,
                        input logic p, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
      logic [31:0] tgt;
      bit          next_stall;
      exp_t        e;
      rst_n            = r;
      fif.Stall        = s;
      fif.Flush        = f;
      fif.PCSrc        = p;
      fif.BranchTarget = bt;
      fif.Jump         = j;
      fif.JumpTarget   = jt;

      next_stall = 1'b0;
      if (!r) begin
         m_pc = TB_RESET_PC; make_bubble(); m_fault = 1'b0;
         m_boot = 1'b1; m_fc = 0; m_sc = 0; m_rc = 0;
      end else begin
         if (m_in_stall) m_sc = m_sc + 1;
         if (m_boot) begin
            m_boot = 1'b0;
            make_bubble();
         end else if (p || j) begin
            tgt = p ? bt : jt;
            if (tgt % 4 != 0) m_fault = 1'b1;
            m_pc = tgt - (tgt % 4);
            make_bubble();
            m_rc = m_rc + 1;
         end else if (s) begin
            next_stall = 1'b1;
         end else if (f) begin
            m_pc = m_pc + 4;
            make_bubble();
         end else begin
            m_instr = mem_word(m_pc);
            m_pcout = m_pc;
            m_pc    = m_pc + 4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
            m_fc    = m_fc + 1;
         end
      end
      m_in_stall = next_stall;

      e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.pcout = m_pcout;
      e.valid = m_valid; e.fault = m_fault; e.fc = m_fc; e.sc = m_sc; e.rc = m_rc;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: one scoreboard record per rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("IMemAddr",       fif.IMemAddr,       e.addr);
            chk("InstructionOut", fif.InstructionOut, e.instr);
            chk("PCAddResultOut", fif.PCAddResultOut, e.pc4);
            chk("PCOut",          fif.PCOut,          e.pcout);
            chk("ValidOut",       {31'd0, fif.ValidOut},   {31'd0, e.valid});
            chk("AlignFault",     {31'd0, fif.AlignFault}, {31'd0, e.fault});
`ifdef FETCH_PERF_CNT_EN
            chk("FetchCount",     fif.FetchCount,    e.fc);
            chk("StallCount",     fif.StallCount,    e.sc);
            chk("RedirectCount",  fif.RedirectCount, e.rc);
`endif
            $display("edge t=%0t addr=%h instr=%h pc4=%h pc=%h valid=%0b fault=%0b",
                     $time, fif.IMemAddr, fif.InstructionOut, fif.PCAddResultOut,
                     fif.PCOut, fif.ValidOut, fif.AlignFault);
         end else if (!done) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_underflow actual=empty required=record t=%0t", $time);
         end
      end
   end

   initial begin
      n_assert = 0;
      n_fail   = 0;
      done     = 1'b0;
      m_pc = TB_RESET_PC; m_instr = TB_NOP; m_pc4 = 0; m_pcout = 0;
      m_valid = 0; m_fault = 0; m_boot = 1; m_in_stall = 0;
      m_fc = 0; m_sc = 0; m_rc = 0;

      // Reset for two edges, then BOOT
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      // Fetch 0 and 4, reaching PC=8
      run(2);
      // Stall three edges at PC=8, one with Flush also set
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      run(3);
      // Branch wins over jump and stall
      drive(1, 1, 0, 1, 32'h40, 1, 32'h80);
      run(2);
      // Misaligned jump target, fault must persist
      drive(1, 0, 0, 0, 0, 1, 32'h102);
      run(10);
      // Flush only
      drive(1, 0, 1, 0, 0, 0, 0);
      run(1);
      // PC wrap at the top of the address space
      drive(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      run(2);
      // Reset pulse in the middle of a stall with a pending branch
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 1, 32'h10, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      run(3);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         logic        r, s, f, p, j;
         logic [31:0] bt, jt;
         r  = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         s  = ($urandom_range(0, 99) < 25);
         f  = ($urandom_range(0, 99) < 12);
         p  = ($urandom_range(0, 99) < 8);
         j  = ($urandom_range(0, 99) < 8);
         bt = $urandom();
         jt = $urandom();
         if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
         drive(r, s, f, p, bt, j, jt);
      end

      done = 1'b1;
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
